logic_unit_arbiter: RTL

- Shares one 16-bit logic unit between two requesters.
- Arbitrates with round-robin priority.
- Registers each operation's result in a one-entry output buffer.
- Returns each result through a valid/ready handshake, tagged with the requester ID.
- Sits between the instruction-side and scratch-side consumers and the shared logic unit in the ALU datapath.

---
 rtl/logic_unit_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// ============================================================================
// logic_unit_arbiter
// ----------------------------------------------------------------------------
// Shares one 16-bit combinational logic unit (AND / OR / XOR / NOT) between
// two requesters. These are the instruction-side and scratch-side consumers
// in the ALU datapath.
//
// Arbitration is round-robin. When both requesters are valid, the one that
// did not win last time is granted. The selected operation's result is
// captured in a one-entry output buffer. The buffer is returned to the
// consumer through a valid/ready handshake and tagged with the requester ID.
//
// The buffer is pass-through. A buffered result can be consumed and a new
// one loaded on the same clock edge. This gives one operation per cycle
// while res_ready stays high.
//
// Optional feature macro:
//   LU_ARB_STATS_EN - adds grant_cnt0 / grant_cnt1. These are saturating
//                     16-bit counts of accepted operations per requester.
//
// Parameters:
//   WIDTH       operand/result width; the logic unit is fixed at 16 bits,
//               so only 16 is supported.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   reqN_valid  requester N presents an operation
//   reqN_ready  requester N's operation is accepted this cycle
//   reqN_x/y    requester N operands
//   reqN_op     00 X&Y, 01 X|Y, 10 X^Y, 11 ~X
//   res_valid   output buffer holds a result
//   res_ready   consumer takes the buffered result
//   res_data    registered logic-unit result
//   res_id      requester that issued the buffered result
//   grant_cnt0/1  accepted-operation counts (LU_ARB_STATS_EN only)
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
`ifdef LU_ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    // Output buffer occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Logic-unit operation encodings
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    buf_state_t       state;
    logic             last_grant;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] lu_out;

    // Grant decision.
    // The buffer can take a new result when it is empty, or when its
    // current result leaves this cycle. Reset blocks every grant, so no
    // handshake can complete in a reset cycle.
    // For a contended cycle, last_grant == 1 means requester 0 is owed
    // the next grant, and last_grant == 0 means requester 1 is owed it.
    always_comb begin
        can_accept = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        can_accept = !rst && ((state == EMPTY) || res_ready);
        grant0     = can_accept && req0_valid && (!req1_valid ||  last_grant);
        grant1     = can_accept && req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux feeding the shared logic unit.
    // Requester 0 is the default selection. When there is no grant, the mux
    // output is simply not captured.
    always_comb begin
        sel_x  = req0_x;
        sel_y  = req0_y;
        sel_op = req0_op;
        if (grant1) begin
            sel_x  = req1_x;
            sel_y  = req1_y;
            sel_op = req1_op;
        end
    end

    // Shared combinational logic unit
    always_comb begin
        lu_out = '0;
        case (sel_op)
            OP_AND:  lu_out = sel_x & sel_y;
            OP_OR:   lu_out = sel_x | sel_y;
            OP_XOR:  lu_out = sel_x ^ sel_y;
            OP_NOT:  lu_out = ~sel_x;
            default: lu_out = '0;
        endcase
    end

    // Output buffer state machine.
    // On a new acceptance, the buffer is always loaded and stays FULL, even
    // if the old result is being consumed on the same edge. With no
    // acceptance, a consumed result empties the buffer. Otherwise the data
    // and ID are held, so they remain stable under backpressure.
    // last_grant resets to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            state      <= FULL;
            res_data_q <= lu_out;
            res_id_q   <= grant1;
            last_grant <= grant1;
        end else if ((state == FULL) && res_ready) begin
            state      <= EMPTY;
        end
    end

    assign res_valid = (state == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef LU_ARB_STATS_EN
    // Per-requester acceptance counters.
    // These saturate rather than wrap, so a long run never reports a
    // misleadingly small count.
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= 16'h0000;
            grant_cnt1_q <= 16'h0000;
        end else begin
            if (grant0 && (grant_cnt0_q != 16'hFFFF)) begin
                grant_cnt0_q <= grant_cnt0_q + 16'h0001;
            end
            if (grant1 && (grant_cnt1_q != 16'hFFFF)) begin
                grant_cnt1_q <= grant_cnt1_q + 16'h0001;
            end
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`else
    // Statistics disabled: no counters and no counter ports.
`endif

endmodule
